conv_channel_accum_align: RTL and testbench
===========================================

// Module: conv_channel_accum_align
// PURPOSE
//  Reduces CHANNEL_NUM_IN consecutive per-input-channel partial sums into one output pixel.
//  Applies saturation and an optional ReLU, then buffers results in an internal FIFO.
//  Releases results to downstream through a valid/ready port only after a prefill threshold, giving an aligned output burst.
//  Sits between the 3x3 conv core and the layer output; replaces the fixed 128-channel adder and the vendor alignment FIFO.
// PARAMETERS
//  DATA_WIDTH      16   signed two's-complement width of pxl_in and pxl_out
//  CHANNEL_NUM_IN  128  partial sums accumulated per output pixel (>=1)
//  CHANNEL_NUM_OUT 128  output channels per frame
//  IMAGE_WIDTH     32   output frame width
//  IMAGE_HEIGHT    32   output frame height
//  FIFO_DEPTH      64   result buffer entries (power of 2, >=2)
//  PREFILL         32   entries required before the first release (1..FIFO_DEPTH)
//  ACT_MODE        0    0 = pass-through, 1 = ReLU (negative results -> 0)
// PORTS
//  clk         in   1                  rising-edge clock
//  reset       in   1                  asynchronous reset, active-low (0 = reset)
//  valid_in    in   1                  pxl_in carries one partial sum this cycle
//  pxl_in      in   DATA_WIDTH         signed partial sum, channel-minor order
//  ready_in    in   1                  downstream can accept pxl_out this cycle
//  pxl_out     out  DATA_WIDTH         accumulated, saturated, activated result
//  valid_out   out  1                  pxl_out valid; transfer when valid_out & ready_in
//  frame_done  out  1                  one-cycle pulse when the last result of a frame is transferred
//  overflow    out  1                  sticky: a result was dropped because the FIFO was full
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored, including the output register
// BEHAVIOUR
//  Reset: reset=0 clears acc, the channel counter, the frame counter, the FIFO pointers and the FSM (IDLE).
//   While reset=0: pxl_out=0, valid_out=0, frame_done=0, overflow=0, fifo_count=0.
//   Reset mid-frame discards partial accumulations and buffered results.
//  Accumulate:
//   - Accumulator width ACC_W = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1.
//   - Each valid_in adds sign-extended pxl_in to acc; ch_cnt counts 0..CHANNEL_NUM_IN-1.
//   - On the beat with ch_cnt == CHANNEL_NUM_IN-1: the sum (acc + pxl_in) is saturated to [-2^(DW-1), 2^(DW-1)-1].
//     If ACT_MODE==1, ReLU is applied after saturation.
//     The result is written to the FIFO on the next edge; acc restarts at 0 and ch_cnt wraps to 0.
//   - Beats with valid_in=0 are ignored; gaps between beats are legal at any position.
//  FIFO:
//   - First-word-fall-through; the head is held in the pxl_out register.
//   - A write and a pop in the same cycle are both accepted, including when count == FIFO_DEPTH.
//   - A write when full with no pop is dropped; overflow is set and stays set until reset.
//   - fifo_count never exceeds FIFO_DEPTH.
//  FSM:
//   IDLE   : valid_out forced 0; data accumulates in the FIFO.
//            -> STREAM when fifo_count >= PREFILL.
//            -> DRAIN when the last result of the frame has been written (frame shorter than PREFILL).
//   STREAM : valid_out = head present.
//            -> DRAIN when result number FRAME_PIX = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM_OUT has been written.
//   DRAIN  : valid_out = head present.
//            -> IDLE on the transfer of the final result of the frame; frame_done pulses that cycle.
//   - Results of the next frame may be written during DRAIN. They count toward the next frame and are not released until that frame's PREFILL is met.
//  Latency: the last partial sum at edge N gives FIFO write at N+1 and valid_out at N+2, provided the FSM is in STREAM or DRAIN.
//  Handshake: once valid_out=1 it holds, and pxl_out stays stable, until valid_out & ready_in.
// TESTING  (DW=16, CH_IN=4, CH_OUT=1, 2x2 image, FIFO_DEPTH=8, PREFILL=3 unless noted)
//  1. Frame of 16 partials 1,2,3,4 repeated, ready_in=1 -> 4 outputs of 10, frame_done one pulse, overflow=0.
//  2. Partials 32767 x4, then -32768 x4 -> outputs 32767 then -32768 (saturated); with ACT_MODE=1 -> 32767, 0.
//  3. Prefill: valid_out stays 0 until the 3rd result is written; then 3 back-to-back outputs, 4th follows.
//  4. ready_in toggled 1010 -> no output lost or duplicated, pxl_out stable while stalled, count order preserved.
//  5. ready_in=0, FIFO_DEPTH=2, PREFILL=2, 3 results -> 3rd dropped, overflow=1 and sticky, fifo_count=2.
//  6. reset pulled low after 6 partials, then a clean frame -> outputs match scenario 1; no stale data.

Source files
------------

// File: rtl/conv_channel_accum_align.sv
// conv_channel_accum_align: channel-sum reduction with saturation,
// optional ReLU and a prefill-gated first-word-fall-through buffer.
`timescale 1ns/1ps
module conv_channel_accum_align #(
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 128,
  parameter int IMAGE_WIDTH     = 32,
  parameter int IMAGE_HEIGHT    = 32,
  parameter int FIFO_DEPTH      = 64,
  parameter int PREFILL         = 32,
  parameter int ACT_MODE        = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  input  logic                         ready_in,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int ACC_W = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1;
  localparam int CH_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_OUT;
  localparam int FR_W  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int EXT_W = ACC_W - DATA_WIDTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(EXT_W+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(EXT_W+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  logic signed [ACC_W-1:0]      acc_q, acc_d, sum;
  logic [CH_W-1:0]              ch_cnt_q, ch_cnt_d;
  logic                         last_ch;
  logic signed [DATA_WIDTH-1:0] sat, act;
  logic                         res_vld_q, res_vld_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;

  logic [DATA_WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         ovf_q, ovf_d;
  logic                         full, push, pop, head_vld;

  state_e                       state_q, state_d;
  logic [FR_W-1:0]              rd_cnt_q, rd_cnt_d;
  logic                         frame_last, fdone;

  assign last_ch = (ch_cnt_q == CH_W'(CHANNEL_NUM_IN - 1));
  assign sum = acc_q + {{EXT_W{pxl_in[DATA_WIDTH-1]}}, pxl_in};

  // saturate the full channel sum, then optionally clamp negatives
  always_comb begin
    sat = sum[DATA_WIDTH-1:0];
    if (sum > SAT_MAX) sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    act = sat;
    if (ACT_MODE == 1 && sat[DATA_WIDTH-1]) act = '0;
  end

  // channel accumulation; a finished pixel is staged for one cycle
  always_comb begin
    acc_d     = acc_q;
    ch_cnt_d  = ch_cnt_q;
    res_vld_d = 1'b0;
    res_d     = res_q;
    if (valid_in) begin
      if (last_ch) begin
        acc_d     = '0;
        ch_cnt_d  = '0;
        res_vld_d = 1'b1;
        res_d     = act;
      end else begin
        acc_d    = sum;
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end
  end

  assign head_vld  = (cnt_q != '0);
  assign valid_out = (state_q != IDLE) && head_vld;
  assign pop       = valid_out && ready_in;
  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push      = res_vld_q && (!full || pop);
  assign rd_nxt    = rd_ptr_q + PTR_W'(1);

  // buffer pointers, occupancy and the head register
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = ovf_q || (res_vld_q && full && !pop);
    dout_d   = dout_q;
    if (pop) begin
      if (cnt_q > CNT_W'(1)) dout_d = mem[rd_nxt];
      else if (push) dout_d = res_q;
    end else if (!head_vld && push) begin
      dout_d = res_q;
    end
  end

  assign frame_last = (rd_cnt_q == FR_W'(FRAME_PIX - 1));

  // release gating: hold until prefill or a complete short frame
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    fdone    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (int'(cnt_q) >= FRAME_PIX) state_d = DRAIN;
        else if (int'(cnt_q) >= PREFILL) state_d = STREAM;
      end
      STREAM: begin
        if (int'(rd_cnt_q) + int'(cnt_q) >= FRAME_PIX)
          state_d = DRAIN;
      end
      DRAIN: state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      if (frame_last) begin
        rd_cnt_d = '0;
        fdone    = 1'b1;
        state_d  = IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + FR_W'(1);
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      ch_cnt_q  <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      ch_cnt_q  <= ch_cnt_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // result storage; contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= res_q;
  end

  assign pxl_out    = dout_q;
  assign frame_done = fdone;
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_conv_channel_accum_align.sv
// tb_conv_channel_accum_align: random and directed stimulus
// against a queue-based reference of channel sums.
`timescale 1ns/1ps
module tb_conv_channel_accum_align;

  localparam int DW  = 16;
  localparam int CHI = 4;
  localparam int FPX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic vin, vout, fdone, ovf;
  logic rdy = 1'b0;
  logic signed [DW-1:0] pin, pout;
  logic [3:0] cnt;

  logic vin2, rdy2, vout2, fdone2, ovf2;
  logic signed [DW-1:0] pin2, pout2;
  logic [1:0] cnt2;

  conv_channel_accum_align #(
    .DATA_WIDTH(16), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(1),
    .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .FIFO_DEPTH(8),
    .PREFILL(3), .ACT_MODE(0)
  ) dut (
    .clk(clk), .reset(rst_n), .valid_in(vin), .pxl_in(pin),
    .ready_in(rdy), .pxl_out(pout), .valid_out(vout),
    .frame_done(fdone), .overflow(ovf), .fifo_count(cnt)
  );

  conv_channel_accum_align #(
    .DATA_WIDTH(16), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(1),
    .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .FIFO_DEPTH(2),
    .PREFILL(2), .ACT_MODE(1)
  ) dut2 (
    .clk(clk), .reset(rst_n), .valid_in(vin2), .pxl_in(pin2),
    .ready_in(rdy2), .pxl_out(pout2), .valid_out(vout2),
    .frame_done(fdone2), .overflow(ovf2), .fifo_count(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic signed [31:0] got,
                     logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // reference: sum CHI partials, clamp to 16-bit range, optional ReLU
  function automatic int ref_res(int s, bit relu);
    int r;
    r = s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  int exp_q[$];
  int got_q2[$];
  int part_sum = 0;
  int part_n = 0;
  int n_xfer = 0;
  int nfd = 0;
  int rmode = 0;
  int e;
  bit hold = 0;
  logic signed [DW-1:0] hold_v;

  // ready pattern: 0 always, 1 toggle, 2 random 3/4, else stalled
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: rdy = 1'b1;
      1: rdy = ~rdy;
      2: rdy = ($urandom_range(3) != 0);
      default: rdy = 1'b0;
    endcase
  end

  // output monitor away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("stall_vld", vout, 1);
        chk("stall_dat", pout, hold_v);
      end
      if (vout && rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_vld", vout, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", pout, e);
          n_xfer++;
          chk("fdone", fdone, (n_xfer % FPX) == 0);
        end
      end else begin
        chk("fdone_idle", fdone, 0);
      end
      if (fdone) nfd++;
      hold = vout && !rdy;
      hold_v = pout;
      if (vout2 && rdy2) got_q2.push_back(int'(pout2));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(int v);
    vin = 1'b1;
    pin = 16'(v);
    tick(1);
    vin = 1'b0;
    part_sum += v;
    part_n++;
    if (part_n == CHI) begin
      exp_q.push_back(ref_res(part_sum, 1'b0));
      part_sum = 0;
      part_n = 0;
    end
  endtask

  task automatic beat2(int v);
    vin2 = 1'b1;
    pin2 = 16'(v);
    tick(1);
    vin2 = 1'b0;
  endtask

  task automatic frame_1234();
    for (int k = 0; k < FPX; k++)
      for (int c = 1; c <= CHI; c++) beat(c);
  endtask

  task automatic frame_rand();
    for (int k = 0; k < FPX * CHI; k++) begin
      int r;
      int v;
      r = $urandom_range(9);
      if (r == 0) v = 32767;
      else if (r == 1) v = -32768;
      else v = int'($urandom_range(65535)) - 32768;
      beat(v);
      if ($urandom_range(3) == 0) tick($urandom_range(3, 1));
    end
  endtask

  task automatic wait_drain(string tag);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    chk(tag, exp_q.size(), 0);
    tick(3);
  endtask

  task automatic chk_reset_outs();
    chk("rst_pxl", pout, 0);
    chk("rst_vld", vout, 0);
    chk("rst_fd", fdone, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_vld2", vout2, 0);
    chk("rst_cnt2", cnt2, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    vin = 1'b0; pin = '0;
    vin2 = 1'b0; pin2 = '0; rdy2 = 1'b0;
    tick(3);
    chk_reset_outs();
    rst_n = 1'b1;
    tick(2);

    // plain frame of 10s
    rmode = 0;
    frame_1234();
    wait_drain("s1_drain");
    chk("s1_n", n_xfer, 4);
    chk("s1_fd", nfd, 1);
    chk("s1_ovf", ovf, 0);

    // prefill gating and release latency
    for (int k = 0; k < 2 * CHI; k++) beat(k + 1);
    tick(6);
    chk("pre_vld", vout, 0);
    chk("pre_cnt", cnt, 2);
    for (int k = 0; k < CHI; k++) beat(-k);
    lat = 0;
    while (!vout && lat < 10) begin
      tick(1);
      lat++;
    end
    chk("pre_lat", lat, 2);
    tick(1);
    chk("pre_b2b", vout, 1);
    for (int k = 0; k < CHI; k++) beat(7);
    wait_drain("s3_drain");
    chk("s3_fd", nfd, 2);

    // saturation, both polarities
    for (int k = 0; k < CHI; k++) beat(32767);
    for (int k = 0; k < CHI; k++) beat(-32768);
    for (int k = 0; k < 2 * CHI; k++) beat(int'($urandom_range(2000)) - 1000);
    wait_drain("s2_drain");
    rdy2 = 1'b1;
    for (int k = 0; k < CHI; k++) beat2(32767);
    for (int k = 0; k < CHI; k++) beat2(-32768);
    beat2(100); beat2(-30); beat2(7); beat2(-80);
    beat2(1000); beat2(2000); beat2(-500); beat2(3);
    tick(8);
    chk("relu_n", got_q2.size(), 4);
    if (got_q2.size() == 4) begin
      chk("relu_0", got_q2[0], 32767);
      chk("relu_1", got_q2[1], 0);
      chk("relu_2", got_q2[2], 0);
      chk("relu_3", got_q2[3], 2503);
    end
    chk("relu_ovf", ovf2, 0);

    // toggled and random back-pressure, random data and gaps
    rmode = 1;
    frame_rand();
    frame_rand();
    wait_drain("s4_tog");
    rmode = 2;
    for (int f = 0; f < 6; f++) frame_rand();
    wait_drain("s4_rand");
    chk("s4_fd", nfd, 11);
    chk("s4_ovf", ovf, 0);
    chk("s4_cnt", cnt, 0);

    // reset in the middle of a frame
    rmode = 0;
    for (int k = 0; k < 6; k++) beat(k + 9);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    exp_q.delete();
    part_sum = 0;
    part_n = 0;
    n_xfer = 0;
    nfd = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    frame_1234();
    wait_drain("s6_drain");
    chk("s6_n", n_xfer, 4);
    chk("s6_fd", nfd, 1);

    // overflow on the shallow instance
    rdy2 = 1'b0;
    for (int k = 0; k < 3 * CHI; k++) beat2(1);
    tick(4);
    chk("ovf_set", ovf2, 1);
    chk("ovf_cnt", cnt2, 2);
    chk("ovf_vld", vout2, 1);
    chk("ovf_head", pout2, 4);
    rdy2 = 1'b1;
    tick(4);
    rdy2 = 1'b0;
    tick(2);
    chk("ovf_sticky", ovf2, 1);
    chk("ovf_empty", cnt2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
